// File: rtl/vga_timing_ctrl.sv
// Raster timing generator with pixel-rate divider, registered sync/blanking outputs,
// and a debounced mode button that steps the display-mode state only at frame boundaries.
module vga_timing_ctrl #(
    parameter int H_ACTIVE        = 640,
    parameter int H_FP            = 16,
    parameter int H_SYNC          = 96,
    parameter int H_BP            = 48,
    parameter int V_ACTIVE        = 480,
    parameter int V_FP            = 10,
    parameter int V_SYNC          = 2,
    parameter int V_BP            = 33,
    parameter int CLK_DIV         = 4,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_mode,
    output logic [9:0] hcnt,
    output logic [9:0] vcnt,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic       frame_start,
    output logic [1:0] state
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

    function automatic logic hsync_level(input logic [9:0] h);
        return !((h >= HS_START) && (h < HS_END));
    endfunction

    function automatic logic vsync_level(input logic [9:0] v);
        return !((v >= VS_START) && (v < VS_END));
    endfunction

    function automatic logic visible(input logic [9:0] h, input logic [9:0] v);
        return (h < H_VIS) && (v < V_VIS);
    endfunction

    logic [DIV_W-1:0] div;
    logic             pix_tick;
    logic             frame_wrap;
    logic [9:0]       hcnt_next;
    logic [9:0]       vcnt_next;

    always_comb begin
        pix_tick   = (div == DIV_LAST);
        hcnt_next  = hcnt;
        vcnt_next  = vcnt;
        frame_wrap = 1'b0;
        if (pix_tick) begin
            if (hcnt == H_LAST) begin
                hcnt_next = '0;
                if (vcnt == V_LAST) begin
                    vcnt_next  = '0;
                    frame_wrap = 1'b1;
                end else begin
                    vcnt_next = vcnt + 10'd1;
                end
            end else begin
                hcnt_next = hcnt + 10'd1;
            end
        end
    end

    // Sync and blanking are derived from the next counter values so they land on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div         <= '0;
            hcnt        <= '0;
            vcnt        <= '0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            video_on    <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            div         <= pix_tick ? '0 : div + 1'b1;
            hcnt        <= hcnt_next;
            vcnt        <= vcnt_next;
            hsync       <= hsync_level(hcnt_next);
            vsync       <= vsync_level(vcnt_next);
            video_on    <= visible(hcnt_next, vcnt_next);
            frame_start <= frame_wrap;
        end
    end

    logic            sync1;
    logic            sync2;
    logic            btn_db;
    logic            btn_db_q;
    logic [DB_W-1:0] db_cnt;
    logic            pending;
    logic            btn_rise;

    assign btn_rise = btn_db & ~btn_db_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            btn_db   <= 1'b0;
            btn_db_q <= 1'b0;
            db_cnt   <= '0;
            pending  <= 1'b0;
            state    <= 2'b00;
        end else begin
            sync1    <= btn_mode;
            sync2    <= sync1;
            btn_db_q <= btn_db;
            if (sync2 == btn_db) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                btn_db <= sync2;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
            // A press landing on the boundary edge survives the clear and waits for the next frame.
            pending <= (pending & ~frame_wrap) | btn_rise;
            if (frame_wrap && pending) begin
                state <= state + 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Self-checking bench for vga_timing_ctrl using a reduced raster so whole frames fit in a short run.
module tb_vga_timing_ctrl;

    localparam int CD    = 4;
    localparam int DB    = 8;
    localparam int HA    = 16;
    localparam int HFP   = 2;
    localparam int HS    = 4;
    localparam int HBP   = 3;
    localparam int VA    = 10;
    localparam int VFP   = 2;
    localparam int VS    = 2;
    localparam int VBP   = 3;
    localparam int HT    = HA + HFP + HS + HBP;
    localparam int VT    = VA + VFP + VS + VBP;
    localparam int FRAME = HT * VT * CD;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       btn_mode = 1'b0;
    logic [9:0] hcnt;
    logic [9:0] vcnt;
    logic       hsync;
    logic       vsync;
    logic       video_on;
    logic       frame_start;
    logic [1:0] state;

    int n_checks = 0;
    int n_fail   = 0;

    vga_timing_ctrl #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .CLK_DIV(CD), .DEBOUNCE_CYCLES(DB)
    ) dut (
        .clk(clk), .rst(rst), .btn_mode(btn_mode),
        .hcnt(hcnt), .vcnt(vcnt), .hsync(hsync), .vsync(vsync),
        .video_on(video_on), .frame_start(frame_start), .state(state)
    );

    always #5 clk = ~clk;

    // Reference model: clocks since reset, a window of raw button samples, and mode bookkeeping.
    int         m_n;
    logic [DB:0] hist;
    logic       m_db;
    logic       m_rose;
    logic       m_pend;
    logic [1:0] m_state;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_n     <= 0;
            hist    <= '0;
            m_db    <= 1'b0;
            m_rose  <= 1'b0;
            m_pend  <= 1'b0;
            m_state <= 2'b00;
        end else begin
            m_n  <= m_n + 1;
            hist <= {hist[DB-1:0], btn_mode};
            if (hist[DB:1] == {DB{~m_db}}) m_db <= ~m_db;
            m_rose <= ~m_db && (hist[DB:1] == {DB{1'b1}});
            if (((m_n + 1) % FRAME) == 0) begin
                if (m_pend) m_state <= m_state + 2'd1;
                m_pend <= m_rose;
            end else begin
                m_pend <= m_pend | m_rose;
            end
        end
    end

    function automatic logic [25:0] expected(input int n, input logic [1:0] st);
        int p, h, v;
        logic hs, vs, vo, fs;
        p  = n / CD;
        h  = p % HT;
        v  = (p / HT) % VT;
        hs = !((h >= HA + HFP) && (h < HA + HFP + HS));
        vs = !((v >= VA + VFP) && (v < VA + VFP + VS));
        vo = (h < HA) && (v < VA);
        fs = (n > 0) && ((n % FRAME) == 0);
        return {10'(h), 10'(v), hs, vs, vo, fs, st};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        logic [25:0] got;
        @(negedge clk);
        if (!rst) begin
            got = {hcnt, vcnt, hsync, vsync, video_on, frame_start, state};
            check($sformatf("cycle%0d", m_n), 32'(got), 32'(expected(m_n, m_state)));
        end
    endtask

    task automatic do_reset();
        btn_mode = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_to(input int target);
        for (int i = 0; i < 2 * FRAME && m_n < target; i++) tick();
    endtask

    task automatic wait_frame();
        for (int i = 0; i < FRAME + 2; i++) begin
            tick();
            if (m_n > 0 && (m_n % FRAME) == 0) break;
        end
    endtask

    task automatic press(input int hold);
        btn_mode = 1'b1;
        repeat (hold) tick();
        btn_mode = 1'b0;
        repeat (DB + 4) tick();
    endtask

    typedef struct {
        int   h;
        int   v;
        logic hs;
        logic vs;
        logic vo;
    } vec_t;

    vec_t vecs[13];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, t1, nfs, nhs, nvs, nvo, base;

        vecs[0]  = '{0, 0, 1'b1, 1'b1, 1'b1};
        vecs[1]  = '{15, 9, 1'b1, 1'b1, 1'b1};
        vecs[2]  = '{16, 0, 1'b1, 1'b1, 1'b0};
        vecs[3]  = '{0, 10, 1'b1, 1'b1, 1'b0};
        vecs[4]  = '{17, 3, 1'b1, 1'b1, 1'b0};
        vecs[5]  = '{18, 3, 1'b0, 1'b1, 1'b0};
        vecs[6]  = '{21, 3, 1'b0, 1'b1, 1'b0};
        vecs[7]  = '{22, 3, 1'b1, 1'b1, 1'b0};
        vecs[8]  = '{24, 11, 1'b1, 1'b1, 1'b0};
        vecs[9]  = '{5, 12, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{5, 13, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{5, 14, 1'b1, 1'b1, 1'b0};
        vecs[12] = '{24, 16, 1'b1, 1'b1, 1'b0};

        // Asynchronous reset values before any clock edge.
        #2 rst = 1'b1;
        #1;
        check("rst_hcnt", 32'(hcnt), 0);
        check("rst_vcnt", 32'(vcnt), 0);
        check("rst_sync", 32'({hsync, vsync}), 3);
        check("rst_video_on", 32'(video_on), 1);
        check("rst_frame_start", 32'(frame_start), 0);
        check("rst_state", 32'(state), 0);
        @(negedge clk);
        rst = 1'b0;

        // Raster probe points.
        for (int k = 0; k < 13; k++) begin
            do_reset();
            repeat (CD * (vecs[k].v * HT + vecs[k].h)) tick();
            check($sformatf("vec%0d_hcnt", k), 32'(hcnt), 32'(vecs[k].h));
            check($sformatf("vec%0d_vcnt", k), 32'(vcnt), 32'(vecs[k].v));
            check($sformatf("vec%0d_hsync", k), 32'(hsync), 32'(vecs[k].hs));
            check($sformatf("vec%0d_vsync", k), 32'(vsync), 32'(vecs[k].vs));
            check($sformatf("vec%0d_video_on", k), 32'(video_on), 32'(vecs[k].vo));
        end

        // Two free-running frames: pulse count, period, sync widths.
        do_reset();
        t0 = -1; t1 = -1; nfs = 0; nhs = 0; nvs = 0; nvo = 0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            tick();
            if (frame_start) begin
                nfs++;
                if (t0 < 0) t0 = i; else if (t1 < 0) t1 = i;
            end
            if (!hsync) nhs++;
            if (!vsync) nvs++;
            if (video_on) nvo++;
        end
        check("frame_pulses", 32'(nfs), 2);
        check("frame_period", 32'(t1 - t0), FRAME);
        check("hsync_low_clks", 32'(nhs), 2 * VT * HS * CD);
        check("vsync_low_clks", 32'(nvs), 2 * VS * HT * CD);
        check("video_on_clks", 32'(nvo), 2 * HA * VA * CD);

        // Four clean presses, one per frame.
        do_reset();
        run_to(400);
        for (int k = 0; k < 4; k++) begin
            press(20);
            repeat (20) tick();
            check($sformatf("press%0d_hold", k), 32'(state), 32'(k % 4));
            wait_frame();
            check($sformatf("press%0d_fs", k), 32'(frame_start), 1);
            check($sformatf("press%0d_step", k), 32'(state), 32'((k + 1) % 4));
            repeat (400) tick();
        end

        // Bounce shorter than the debounce window.
        for (int k = 0; k < 10; k++) begin
            btn_mode = ~btn_mode;
            repeat (3) tick();
        end
        btn_mode = 1'b0;
        wait_frame();
        check("bounce_no_step", 32'(state), 0);

        // Three presses in one frame collapse into one step.
        repeat (300) tick();
        repeat (3) press(20);
        wait_frame();
        check("three_press_step", 32'(state), 1);

        // Debounced rise lands on the frame_start cycle: step deferred one frame.
        base = m_n + FRAME;
        run_to(base - DB - 2);
        btn_mode = 1'b1;
        wait_frame();
        check("boundary_no_step", 32'(state), 1);
        repeat (20) tick();
        btn_mode = 1'b0;
        wait_frame();
        check("boundary_late_step", 32'(state), 2);

        // Pending already set and a new rise coincides with the mode update.
        repeat (300) tick();
        press(20);
        base = m_n - (m_n % FRAME) + FRAME;
        run_to(base - DB - 3);
        btn_mode = 1'b1;
        wait_frame();
        check("reset_pending_step1", 32'(state), 3);
        repeat (20) tick();
        btn_mode = 1'b0;
        wait_frame();
        check("reset_pending_step2", 32'(state), 0);

        // Mid-frame reset with state 10 and a pending step.
        press(20);
        wait_frame();
        repeat (300) tick();
        press(20);
        wait_frame();
        check("pre_reset_state", 32'(state), 2);
        run_to(m_n + CD * (8 * HT + 12));
        press(20);
        #2 rst = 1'b1;
        #1;
        check("midrst_hcnt", 32'(hcnt), 0);
        check("midrst_vcnt", 32'(vcnt), 0);
        check("midrst_state", 32'(state), 0);
        check("midrst_outs", 32'({hsync, vsync, video_on, frame_start}), 4'b1110);
        @(negedge clk);
        rst = 1'b0;
        wait_frame();
        check("post_rst_frame1", 32'(state), 0);
        wait_frame();
        check("post_rst_frame2", 32'(state), 0);

        // Randomised button activity against the model.
        do_reset();
        while (m_n < 3 * FRAME) begin
            btn_mode = 1'($urandom_range(0, 1));
            repeat ($urandom_range(1, 3 * DB)) tick();
        end
        btn_mode = 1'b0;
        repeat (2 * DB) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
